// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared multdiv state encoding and default widths
package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, trial subtract, select
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // One extra guard bit so the borrow of the trial subtraction is its sign.
  always_comb begin
    r_shift = {r_i, q_msb_i};
    trial   = r_shift - {2'b00, d_i};
    q_bit_o = ~trial[WIDTH+1];
    r_o     = q_bit_o ? trial[WIDTH:0] : r_shift[WIDTH:0];
  end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - iterative restoring divider paced by an external iteration counter
// Optional two's-complement operation when DIV_SIGNED_EN is defined.
module iter_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_clr,
  output logic             busy,
  output logic             ready,
  output logic             exception,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   step_r;
  logic             step_bit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             ovf_flag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_bit)
  );

  assign q_next = {q_q[WIDTH-2:0], step_bit};

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic neg_q_q, neg_r_q, ovf_q;

  assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fix    = neg_q_q ? -q_next : q_next;
  assign r_fix    = neg_r_q ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];
  assign ovf_flag = ovf_q;

  // Sign flags follow the operands accepted from IDLE; the MIN/-1 case still
  // runs the full iteration, the magnitude path already yields the wrapped result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_q <= dividend[WIDTH-1];
      ovf_q   <= (dividend == MIN_NEG) && (divisor == '1);
    end
  end
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign q_fix    = q_next;
  assign r_fix    = step_r[WIDTH-1:0];
  assign ovf_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_clr_q <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      exc_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_clr_q <= cnt_clr_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      exc_q     <= exc_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_clr_d = cnt_clr_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    exc_d     = exc_q;
    quot_d    = quot_q;
    rem_d     = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr_d = 1'b1;
        busy_d    = 1'b0;
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            exc_d   = 1'b1;
            quot_d  = '0;
            rem_d   = '0;
          end else begin
            state_d   = ST_RUN;
            d_d       = b_mag;
            q_d       = a_mag;
            r_d       = '0;
            cnt_clr_d = 1'b0;
            busy_d    = 1'b1;
            exc_d     = 1'b0;
          end
        end
      end

      ST_RUN: begin
        r_d = step_r;
        q_d = q_next;
        // >= rather than == so a counter that skips a value still terminates.
        if (count >= CNT_W'(WIDTH)) begin
          state_d   = ST_DONE;
          ready_d   = 1'b1;
          cnt_clr_d = 1'b1;
          busy_d    = 1'b0;
          quot_d    = q_fix;
          rem_d     = r_fix;
          exc_d     = ovf_flag;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_clr_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign cnt_clr   = cnt_clr_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign exception = exc_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - randomized self-checking bench for iter_divider with counter model
module tb_iter_divider;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [5:0]  count = '0;
  logic        cnt_clr, busy, ready, exception;
  logic [31:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .count     (count),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .ready     (ready),
    .exception (exception),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Upstream iteration counter: advances on falling edges, held at 0 by cnt_clr.
  always @(negedge clk) count <= cnt_clr ? 6'd0 : count + 6'd1;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 0; r = 0; e = 1'b1;
`ifdef DIV_SIGNED_EN
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; e = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
`else
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
`endif
  endfunction

  // Issues one operation from the post-edge phase and observes it to completion.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic e, output int busy_n, output logic clr_low,
                        output logic rdy_after, output logic e_after);
    lat = -1; busy_n = 0; clr_low = 1'b0; q = 'x; r = 'x; e = 1'bx;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (!cnt_clr) clr_low = 1'b1;
      if (ready) begin
        lat = k; q = quotient; r = remainder; e = exception;
        break;
      end
      if (busy) busy_n++;
    end
    @(posedge clk); #1;
    rdy_after = ready;
    e_after   = exception;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL rst_cnt_clr: got %b want 1", cnt_clr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_vec++; if (exception !== 1'b0) begin n_err++; $display("FAIL rst_exc: got %b want 0", exception); end
    n_vec++; if (quotient !== 32'd0) begin n_err++; $display("FAIL rst_quot: got %h want 0", quotient); end
    n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL rst_rem: got %h want 0", remainder); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith(input int n_rand);
    logic [31:0] ops_a[$], ops_b[$];
    logic [31:0] a, b, q, r, eq, er;
    logic e, ee, clr_low, rdy_after, e_after;
    int lat, busy_n, elat;
    ops_a = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd50, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd7};
    ops_b = '{32'd7,   32'd1,         32'd9, 32'd5,  32'd0,    32'd3, 32'hFFFF_FFFF, 32'd7};
`ifdef DIV_SIGNED_EN
    ops_a.push_back(-32'sd7);        ops_b.push_back(32'd2);
    ops_a.push_back(32'h8000_0000);  ops_b.push_back(32'hFFFF_FFFF);
`endif
    for (int i = 0; i < n_rand; i++) begin
      ops_a.push_back($urandom);
      ops_b.push_back(($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31)));
    end
    foreach (ops_a[i]) begin
      a = ops_a[i]; b = ops_b[i];
      ref_div(a, b, eq, er, ee);
      elat = (b == 0) ? 0 : W;
      do_div(a, b, lat, q, r, e, busy_n, clr_low, rdy_after, e_after);
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL latency %h/%h: got %0d want %0d", a, b, lat, elat); end
      n_vec++; if (q !== eq) begin n_err++; $display("FAIL quotient %h/%h: got %h want %h", a, b, q, eq); end
      n_vec++; if (r !== er) begin n_err++; $display("FAIL remainder %h/%h: got %h want %h", a, b, r, er); end
      n_vec++; if (e !== ee) begin n_err++; $display("FAIL exception %h/%h: got %b want %b", a, b, e, ee); end
      n_vec++; if (busy_n != elat) begin n_err++; $display("FAIL busy_cycles %h/%h: got %0d want %0d", a, b, busy_n, elat); end
      n_vec++; if (clr_low !== (b != 0)) begin n_err++; $display("FAIL cnt_clr_release %h/%h: got %b want %b", a, b, clr_low, b != 0); end
      n_vec++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL ready_pulse %h/%h: got %b want 0", a, b, rdy_after); end
      n_vec++; if (e_after !== ee) begin n_err++; $display("FAIL exception_hold %h/%h: got %b want %b", a, b, e_after, ee); end
    end
  endtask

  task automatic test_start_ignored;
    time t0;
    int lat;
    bit hit;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; t0 = $time;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk); #1;
      if (count == 6'd10) hit = 1;
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL ign_count_reach: got %0d want 10", count); end
    start = 1'b1; dividend = 32'd999; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (ready) begin lat = int'(($time - t0) / 10); break; end
      @(posedge clk); #1;
    end
    n_vec++; if (lat != W) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat, W); end
    n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL ign_quotient: got %h want %h", quotient, 32'd14); end
    n_vec++; if (remainder !== 32'd2) begin n_err++; $display("FAIL ign_remainder: got %h want %h", remainder, 32'd2); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r, eq, er;
    logic e, ee, clr_low, rdy_after, e_after;
    int lat, busy_n, seen_busy;
    start = 1'b1; dividend = 32'd20; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && !ready; k++) begin @(posedge clk); #1; end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready: got %b want 1", ready); end
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    seen_busy = 0;
    repeat (3) begin
      if (busy) seen_busy++;
      @(posedge clk); #1;
    end
    n_vec++; if (seen_busy != 0) begin n_err++; $display("FAIL b2b_done_start: got %0d busy cycles want 0", seen_busy); end
    ref_div(32'd77, 32'd4, eq, er, ee);
    do_div(32'd77, 32'd4, lat, q, r, e, busy_n, clr_low, rdy_after, e_after);
    n_vec++; if (q !== eq || r !== er || lat != W) begin
      n_err++; $display("FAIL b2b_followup: got %h r %h lat %0d want %h r %h lat %0d", q, r, lat, eq, er, W);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    logic e, clr_low, rdy_after, e_after;
    int lat, busy_n;
    bit hit;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk); #1;
      if (count == 6'd10) hit = 1;
    end
    reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (cnt_clr !== 1'b1) begin n_err++; $display("FAIL midrst_cnt_clr: got %b want 1", cnt_clr); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", ready); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
    do_div(32'd50, 32'd5, lat, q, r, e, busy_n, clr_low, rdy_after, e_after);
    n_vec++; if (lat != W) begin n_err++; $display("FAIL midrst_latency: got %0d want %0d", lat, W); end
    n_vec++; if (q !== 32'd10) begin n_err++; $display("FAIL midrst_quotient: got %h want %h", q, 32'd10); end
    n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL midrst_remainder: got %h want 0", r); end
  endtask

  initial begin
    test_reset();
    test_arith(24);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
